// File: rtl/whack_game_core_if.sv
// Signal bundle between the debounced switch bank / display logic and the
// whack-a-mole engine. It has no valid/ready handshake. sw, start and mode
// are levels sampled every clk edge. LED, score_count, lives and game_over
// are registered levels. hit and miss are single-cycle pulses, one per
// scored event.
interface whack_game_core_if #(
  parameter int N_CH    = 16,
  parameter int SCORE_W = 6
);
  logic [N_CH-1:0]    sw;
  logic               start;
  logic               mode;
  logic [N_CH-1:0]    LED;
  logic [SCORE_W-1:0] score_count;
  logic [3:0]         lives;
  logic               hit;
  logic               miss;
  logic               game_over;

  modport master (
    output sw, start, mode,
    input  LED, score_count, lives, hit, miss, game_over
  );

  modport slave (
    input  sw, start, mode,
    output LED, score_count, lives, hit, miss, game_over
  );
endinterface

// File: rtl/whack_game_core.sv
// Whack-a-mole engine: lights one mole at a time (sequential or LFSR order),
// scores matching toggles before a shrinking timeout, charges a life on a
// wrong toggle or a timeout, and ends the game when lives run out.
module whack_game_core #(
  parameter int          N_CH          = 16,
  parameter int          SCORE_W       = 6,
  parameter int          LIVES         = 3,
  parameter int          TIMEOUT_CYC   = 1000,
  parameter int          TIMEOUT_MIN   = 200,
  parameter int          TIMEOUT_STEP  = 100,
  parameter int          SPEEDUP_EVERY = 4,
  parameter int          GAP_CYC       = 50,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  whack_game_core_if.slave        io,
  output logic [2:0]              state_dbg
);

  localparam int PW   = $clog2(N_CH);
  localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int HW   = $clog2(SPEEDUP_EVERY + 1);
  localparam logic [N_CH-1:0]    ONE_CH    = {{(N_CH-1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [N_CH-1:0]    sw_q;
  logic [15:0]        lfsr_q, lfsr_n;
  logic [PW-1:0]      pos_q, pos_n;
  logic [TW-1:0]      limit_q, limit_n;
  logic [HW-1:0]      hcnt_q, hcnt_n;
  logic [TW-1:0]      timer_q, timer_n;
  logic [N_CH-1:0]    led_q, led_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [3:0]         lives_q, lives_n;
  logic               hit_q, hit_n;
  logic               miss_q, miss_n;
  logic               over_q, over_n;

  logic [N_CH-1:0]    tg;
  logic [N_CH-1:0]    pos_oh;
  logic [PW-1:0]      rnd;

  assign tg     = io.sw ^ sw_q;
  assign pos_oh = ONE_CH << pos_q;
  assign rnd    = lfsr_q[PW-1:0];

  // Switch history register; runs through reset so no toggle is seen after it.
  always_ff @(posedge clk) begin
    sw_q <= io.sw;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      pos_q   <= PW'(N_CH - 1);
      limit_q <= TW'(TIMEOUT_CYC);
      hcnt_q  <= '0;
      timer_q <= '0;
      led_q   <= '0;
      score_q <= '0;
      lives_q <= 4'(LIVES);
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      lfsr_q  <= lfsr_n;
      pos_q   <= pos_n;
      limit_q <= limit_n;
      hcnt_q  <= hcnt_n;
      timer_q <= timer_n;
      led_q   <= led_n;
      score_q <= score_n;
      lives_q <= lives_n;
      hit_q   <= hit_n;
      miss_q  <= miss_n;
      over_q  <= over_n;
    end
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_n = state_q;
    lfsr_n  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    pos_n   = pos_q;
    limit_n = limit_q;
    hcnt_n  = hcnt_q;
    timer_n = timer_q;
    led_n   = '0;
    score_n = score_q;
    lives_n = lives_q;
    hit_n   = 1'b0;
    miss_n  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          state_n = S_ARM;
          score_n = '0;
          lives_n = 4'(LIVES);
        end
      end

      S_ARM: begin
        if (io.mode) begin
          // Never repeat the previous mole; the +1 wraps since N_CH is 2^PW.
          pos_n = (rnd == pos_q) ? rnd + PW'(1) : rnd;
        end else begin
          pos_n = pos_q + PW'(1);
        end
        timer_n = '0;
        led_n   = ONE_CH << pos_n;
        state_n = S_SHOW;
      end

      S_SHOW: begin
        led_n   = led_q;
        timer_n = timer_q + TW'(1);
        if (|(tg & ~pos_oh) || (tg == '0 && timer_q == limit_q - TW'(1))) begin
          // Wrong toggle (even alongside the right one) or timeout.
          led_n   = '0;
          miss_n  = 1'b1;
          lives_n = lives_q - 4'd1;
          timer_n = '0;
          state_n = (lives_n == 4'd0) ? S_OVER : S_GAP;
        end else if (tg == pos_oh) begin
          led_n   = '0;
          hit_n   = 1'b1;
          score_n = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
          if (int'(hcnt_q) + 1 >= SPEEDUP_EVERY) begin
            hcnt_n = '0;
            if (int'(limit_q) >= TIMEOUT_MIN + TIMEOUT_STEP) begin
              limit_n = limit_q - TW'(TIMEOUT_STEP);
            end else begin
              limit_n = TW'(TIMEOUT_MIN);
            end
          end else begin
            hcnt_n = hcnt_q + HW'(1);
          end
          timer_n = '0;
          state_n = S_GAP;
        end
      end

      S_GAP: begin
        if (timer_q == TW'(GAP_CYC - 1)) begin
          state_n = S_ARM;
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end

      S_OVER: begin
        if (io.start) begin
          state_n = S_ARM;
          score_n = '0;
          lives_n = 4'(LIVES);
          limit_n = TW'(TIMEOUT_CYC);
          hcnt_n  = '0;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    over_n = (state_n == S_OVER);
  end

  assign io.LED         = led_q;
  assign io.score_count = score_q;
  assign io.lives       = lives_q;
  assign io.hit         = hit_q;
  assign io.miss        = miss_q;
  assign io.game_over   = over_q;
  assign state_dbg      = state_q;

endmodule
